// File: rtl/ov7670_frame_writer_if.sv
// Camera byte stream into the frame writer and its frame-buffer write port.
interface ov7670_frame_writer_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              line_valid;
    logic              frame_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    modport master (
        output byte_data, byte_valid, line_valid, frame_valid,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_data, byte_valid, line_valid, frame_valid,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ov7670_frame_writer.sv
// Pairs RGB565 camera bytes, decimates, converts to RGB444 and writes a frame buffer;
// keeps per-frame statistics and sticky error flags.
module ov7670_frame_writer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DECIM    = 2,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    ov7670_frame_writer_if.slave bus,
    output logic                 frame_done,
    output logic [ADDR_W:0]      frame_pixels,
    output logic [9:0]           frame_lines,
    output logic [15:0]          frame_count,
    output logic                 busy,
    output logic                 overflow,
    output logic                 odd_byte_err
);
    localparam int unsigned DEPTH = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned X_W   = $clog2(H_ACTIVE + 1);
    localparam int unsigned Y_W   = 10;
    localparam int unsigned YC_W  = Y_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              fv_dly_q, fv_dly_d;
    logic              lv_dly_q, lv_dly_d;
    logic              phase_q, phase_d;
    logic [6:0]        hi_q, hi_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [CNT_W-1:0]  wcount_q, wcount_d;
    logic [9:0]        lcount_q, lcount_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_pixels_q, frame_pixels_d;
    logic [9:0]        frame_lines_q, frame_lines_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              odd_q, odd_d;

    logic fv_rise, fv_fall, lv_fall, byte_ok, x_keep, y_keep;

    assign fv_rise = bus.frame_valid & ~fv_dly_q;
    assign fv_fall = ~bus.frame_valid & fv_dly_q;
    assign lv_fall = ~bus.line_valid & lv_dly_q;
    assign byte_ok = bus.byte_valid & bus.line_valid;
    assign x_keep  = ((x_q & X_W'(DECIM - 1)) == '0) && (x_q < X_W'(H_ACTIVE));
    assign y_keep  = ((y_q & Y_W'(DECIM - 1)) == '0) && (YC_W'(y_q) < YC_W'(V_ACTIVE));

    // Byte processing happens before the line-end update so a byte on the HREF
    // falling edge is still paired, and a frame end counts that cycle's write.
    always_comb begin
        state_d        = state_q;
        fv_dly_d       = bus.frame_valid;
        lv_dly_d       = bus.line_valid;
        phase_d        = phase_q;
        hi_d           = hi_q;
        x_d            = x_q;
        y_d            = y_q;
        wcount_d       = wcount_q;
        lcount_d       = lcount_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        frame_lines_d  = frame_lines_q;
        frame_count_d  = frame_count_q;
        overflow_d     = overflow_q;
        odd_d          = odd_q;

        unique case (state_q)
            S_IDLE: begin
                if (fv_rise && enable) begin
                    state_d  = S_ACTIVE;
                    x_d      = '0;
                    y_d      = '0;
                    phase_d  = 1'b0;
                    wcount_d = '0;
                    lcount_d = '0;
                end
            end
            S_ACTIVE: begin
                if (byte_ok) begin
                    if (!phase_q) begin
                        hi_d    = {bus.byte_data[7:4], bus.byte_data[2:0]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_keep && y_keep) begin
                            if (wcount_q == CNT_W'(DEPTH)) begin
                                overflow_d = 1'b1;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = wcount_q[ADDR_W-1:0];
                                wr_data_d = {hi_q[6:3], hi_q[2:0], bus.byte_data[7],
                                             bus.byte_data[4:1]};
                                wcount_d  = wcount_q + CNT_W'(1);
                            end
                        end
                        if (x_q != X_W'(H_ACTIVE)) x_d = x_q + X_W'(1);
                    end
                end
                if (lv_fall) begin
                    if (y_q != '1) y_d = y_q + Y_W'(1);
                    x_d      = '0;
                    lcount_d = lcount_q + 10'(1);
                    if (phase_d) begin
                        odd_d   = 1'b1;
                        phase_d = 1'b0;
                    end
                end
                if (fv_fall) begin
                    state_d        = S_DONE;
                    frame_done_d   = 1'b1;
                    frame_pixels_d = wcount_d;
                    frame_lines_d  = lcount_d;
                    frame_count_d  = frame_count_q + 16'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            fv_dly_q       <= 1'b1;
            lv_dly_q       <= 1'b1;
            phase_q        <= 1'b0;
            hi_q           <= '0;
            x_q            <= '0;
            y_q            <= '0;
            wcount_q       <= '0;
            lcount_q       <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            frame_lines_q  <= '0;
            frame_count_q  <= '0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            odd_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            fv_dly_q       <= fv_dly_d;
            lv_dly_q       <= lv_dly_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            x_q            <= x_d;
            y_q            <= y_d;
            wcount_q       <= wcount_d;
            lcount_q       <= lcount_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            frame_lines_q  <= frame_lines_d;
            frame_count_q  <= frame_count_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            odd_q          <= odd_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign frame_lines  = frame_lines_q;
    assign frame_count  = frame_count_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign odd_byte_err = odd_q;
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench: an 8x4 writer for capture/latency/odd-byte/enable/wrap and a 9x4
// writer whose kept-pixel count exceeds its depth for the overflow case.
module tb_ov7670_frame_writer;
    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] exp_data;
    } pix_vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rst_n, en, en_ovf;
    logic [7:0] byte_data;
    logic byte_valid, line_valid, frame_valid;

    logic        frame_done, busy, overflow, odd_byte_err;
    logic [4:0]  frame_pixels;
    logic [9:0]  frame_lines;
    logic [15:0] frame_count;
    logic        o_frame_done, o_busy, o_overflow, o_odd_byte_err;
    logic [4:0]  o_frame_pixels;
    logic [9:0]  o_frame_lines;
    logic [15:0] o_frame_count;

    int n_cmp = 0;
    int n_err = 0;
    int wn = 0;
    int o_wn = 0;
    int done_cnt = 0;
    logic [3:0]  log_addr [64];
    logic [11:0] log_data [64];
    logic [15:0] exp_fc;

    pix_vec_t pix_tab [6];
    wr_vec_t  wr_tab  [8];

    always #5 clk = ~clk;

    ov7670_frame_writer_if #(.ADDR_W(4)) m_if ();
    ov7670_frame_writer_if #(.ADDR_W(4)) o_if ();

    assign m_if.byte_data   = byte_data;
    assign m_if.byte_valid  = byte_valid;
    assign m_if.line_valid  = line_valid;
    assign m_if.frame_valid = frame_valid;
    assign o_if.byte_data   = byte_data;
    assign o_if.byte_valid  = byte_valid;
    assign o_if.line_valid  = line_valid;
    assign o_if.frame_valid = frame_valid;

    ov7670_frame_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .ADDR_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .bus(m_if.slave),
        .frame_done(frame_done), .frame_pixels(frame_pixels), .frame_lines(frame_lines),
        .frame_count(frame_count), .busy(busy), .overflow(overflow),
        .odd_byte_err(odd_byte_err)
    );

    ov7670_frame_writer #(.H_ACTIVE(9), .V_ACTIVE(4), .DECIM(2), .ADDR_W(4)) u_ovf (
        .clk(clk), .rst_n(rst_n), .enable(en_ovf), .bus(o_if.slave),
        .frame_done(o_frame_done), .frame_pixels(o_frame_pixels),
        .frame_lines(o_frame_lines), .frame_count(o_frame_count), .busy(o_busy),
        .overflow(o_overflow), .odd_byte_err(o_odd_byte_err)
    );

    always @(negedge clk) begin
        if (m_if.wr_en) begin
            if (wn < 64) begin
                log_addr[wn] <= m_if.wr_addr;
                log_data[wn] <= m_if.wr_data;
            end
            wn <= wn + 1;
        end
        if (o_if.wr_en) o_wn <= o_wn + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] pix_color(input int p);
        return (((p / 2) % 2) != 0) ? 16'h001F : 16'hF800;
    endfunction

    task automatic send_line_px(input int npix, input bit extra_hi);
        logic [15:0] col;
        line_valid = 1'b1;
        tick();
        for (int p = 0; p < npix; p++) begin
            col = pix_color(p);
            send_byte(col[15:8]);
            send_byte(col[7:0]);
        end
        if (extra_hi) send_byte(8'hF8);
        line_valid = 1'b0;
        tick();
    endtask

    task automatic start_frame(input logic exp_busy);
        frame_valid = 1'b1;
        tick();
        check("start_busy", busy, exp_busy);
    endtask

    task automatic finish_frame(input int exp_pix, input int exp_lines);
        frame_valid = 1'b0;
        tick();
        exp_fc = exp_fc + 16'd1;
        check("done_pulse", frame_done, 1'b1);
        check("frame_pixels", frame_pixels, exp_pix);
        check("frame_lines", frame_lines, exp_lines);
        check("frame_count", frame_count, exp_fc);
        check("done_busy", busy, 1'b0);
        tick();
        check("done_single", frame_done, 1'b0);
    endtask

    task automatic check_frame_log(input string name, input int base);
        check({name, "_nwr"}, wn - base, 8);
        for (int i = 0; i < 8; i++) begin
            check({name, "_addr"}, log_addr[base + i], wr_tab[i].addr);
            check({name, "_data"}, log_data[base + i], wr_tab[i].data);
        end
    endtask

    initial begin
        int base, dbase;

        pix_tab[0] = '{8'h07, 8'hE0, 12'h0F0};
        pix_tab[1] = '{8'hF8, 8'h00, 12'hF00};
        pix_tab[2] = '{8'h00, 8'h1F, 12'h00F};
        pix_tab[3] = '{8'hFF, 8'hFF, 12'hFFF};
        pix_tab[4] = '{8'h84, 8'h21, 12'h880};
        pix_tab[5] = '{8'h5A, 8'hA5, 12'h552};

        wr_tab[0] = '{4'd0, 12'hF00};
        wr_tab[1] = '{4'd1, 12'h00F};
        wr_tab[2] = '{4'd2, 12'hF00};
        wr_tab[3] = '{4'd3, 12'h00F};
        wr_tab[4] = '{4'd4, 12'hF00};
        wr_tab[5] = '{4'd5, 12'h00F};
        wr_tab[6] = '{4'd6, 12'hF00};
        wr_tab[7] = '{4'd7, 12'h00F};

        exp_fc      = 16'd0;
        rst_n       = 1'b0;
        en          = 1'b1;
        en_ovf      = 1'b0;
        byte_data   = 8'h00;
        byte_valid  = 1'b0;
        line_valid  = 1'b1;
        frame_valid = 1'b1;

        // Reset held with a frame in progress, then released mid-frame.
        repeat (3) tick();
        check("reset_wr", {m_if.wr_en, m_if.wr_addr, m_if.wr_data}, 0);
        check("reset_stats", {frame_done, frame_pixels, frame_lines, frame_count}, 0);
        check("reset_flags", {busy, overflow, odd_byte_err}, 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hA5);
            check("partial_busy", busy, 1'b0);
        end
        line_valid = 1'b0;
        tick();
        frame_valid = 1'b0;
        repeat (2) tick();
        check("partial_no_done", done_cnt, 0);
        check("partial_no_wr", wn, 0);
        check("partial_stats", {frame_done, frame_pixels, frame_lines, frame_count}, 0);

        // Basic 8x4 frame, red/blue alternating every two pixels.
        base = wn;
        start_frame(1'b1);
        for (int l = 0; l < 4; l++) send_line_px(8, 1'b0);
        finish_frame(8, 4);
        tick();
        check_frame_log("basic", base);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_flags", {overflow, odd_byte_err}, 0);

        // Single-pixel frames: conversion and write latency.
        for (int v = 0; v < 6; v++) begin
            start_frame(1'b1);
            line_valid = 1'b1;
            tick();
            byte_data  = pix_tab[v].hi;
            byte_valid = 1'b1;
            tick();
            byte_valid = 1'b0;
            check("lat_after_hi", m_if.wr_en, 1'b0);
            tick();
            byte_data  = pix_tab[v].lo;
            byte_valid = 1'b1;
            tick();
            byte_valid = 1'b0;
            check("lat_wr_en", m_if.wr_en, 1'b1);
            check("lat_addr", m_if.wr_addr, 4'd0);
            check("lat_data", m_if.wr_data, pix_tab[v].exp_data);
            tick();
            check("lat_one_cycle", m_if.wr_en, 1'b0);
            line_valid = 1'b0;
            tick();
            finish_frame(1, 1);
        end

        // Odd byte on line 0; line 1 must restart as a high byte.
        base = wn;
        start_frame(1'b1);
        send_line_px(7, 1'b1);
        check("odd_set", odd_byte_err, 1'b1);
        for (int l = 1; l < 4; l++) send_line_px(8, 1'b0);
        finish_frame(8, 4);
        tick();
        check_frame_log("odd", base);

        // Enable drops mid-frame: the frame still completes.
        base = wn;
        start_frame(1'b1);
        send_line_px(8, 1'b0);
        en = 1'b0;
        for (int l = 1; l < 4; l++) send_line_px(8, 1'b0);
        finish_frame(8, 4);
        tick();
        check("en_drop_nwr", wn - base, 8);

        // Next frame ignored by the disabled writer; overflow writer captures it.
        base  = wn;
        dbase = done_cnt;
        check("ovf_clear", o_overflow, 1'b0);
        en_ovf      = 1'b1;
        frame_valid = 1'b1;
        tick();
        check("ignored_busy", busy, 1'b0);
        check("ovf_busy", o_busy, 1'b1);
        for (int l = 0; l < 6; l++) send_line_px(9, 1'b0);
        check("ignored_busy_end", busy, 1'b0);
        frame_valid = 1'b0;
        tick();
        check("ovf_done", o_frame_done, 1'b1);
        check("ovf_pixels", o_frame_pixels, 5'd8);
        check("ovf_lines", o_frame_lines, 10'd6);
        check("ovf_flag", o_overflow, 1'b1);
        tick();
        check("ovf_nwr", o_wn, 8);
        check("ignored_nwr", wn - base, 0);
        check("ignored_no_done", done_cnt - dbase, 0);
        check("main_no_ovf", overflow, 1'b0);
        en_ovf = 1'b0;

        // frame_count wrap from 0xFFFF.
        en = 1'b1;
        tick();
        force u_dut.frame_count_q = 16'hFFFF;
        tick();
        release u_dut.frame_count_q;
        exp_fc = 16'hFFFF;
        start_frame(1'b1);
        send_line_px(1, 1'b0);
        finish_frame(1, 1);
        check("odd_sticky", odd_byte_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
